// File: rtl/itch_frame_tx.sv
// Wraps one ITCH message per frame in Eth/IPv4/UDP/MoldUDP64 headers and streams it bytewise, MSB first.
// First byte valid 2 cycles after the message handshake; the registered byte holds while txReady is low.
module itch_frame_tx #(
    parameter logic [47:0] DST_MAC    = 48'hA846D2197E2B,
    parameter logic [47:0] SRC_MAC    = 48'h123456789ABC,
    parameter logic [31:0] SRC_IP     = 32'h12345678,
    parameter logic [31:0] DST_IP     = 32'hE0000000,
    parameter logic [15:0] SRC_PORT   = 16'h3E80,
    parameter logic [15:0] DST_PORT   = 16'h2710,
    parameter logic [79:0] SESSION_ID = 80'h0,
    parameter logic [63:0] SEQ_INIT   = 64'd1
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         msgValid,
    output logic         msgReady,
    input  logic [287:0] msgData,
    output logic [7:0]   txData,
    output logic         txValid,
    output logic         txLast,
    input  logic         txReady,
    output logic [63:0]  seqNum,
    output logic [15:0]  dropCnt
);

    typedef enum logic [1:0] {IDLE, CSUM, SEND} state_e;

    state_e        state_q, state_d;
    logic [287:0]  msg_q, msg_d;
    logic [6:0]    len_q, len_d;
    logic [15:0]   csum_q, csum_d;
    logic [6:0]    idx_q, idx_d;
    logic [63:0]   seq_q, seq_d;
    logic [15:0]   drop_q, drop_d;
    logic          rdy_q, rdy_d;
    logic          vld_q, vld_d;
    logic          last_q, last_d;
    logic [7:0]    dat_q, dat_d;

    logic [15:0]   mold_len, ip_len, udp_len;
    logic [19:0]   csum_acc;
    logic [16:0]   fold1;
    logic [15:0]   fold2;
    logic [511:0]  hdr;
    logic [799:0]  frame;
    logic [7:0]    cur_byte;
    logic [6:0]    last_idx;

    always_comb begin
        mold_len = {9'd0, len_q};
        ip_len   = 16'd50 + mold_len;
        udp_len  = 16'd30 + mold_len;
        // Header words with the checksum field taken as zero; id, flags and ttl are zero too.
        csum_acc = 20'(16'h4500) + 20'(ip_len) + 20'(16'h0011)
                 + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
                 + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
        fold1    = {1'b0, csum_acc[15:0]} + {13'd0, csum_acc[19:16]};
        fold2    = fold1[15:0] + {15'd0, fold1[16]};
        hdr = {DST_MAC, SRC_MAC, 16'h0800,
               8'h45, 8'h00, ip_len, 16'h0000, 16'h0000, 8'h00, 8'h11, csum_q, SRC_IP, DST_IP,
               SRC_PORT, DST_PORT, udp_len, 16'h0000,
               SESSION_ID, seq_q, 16'd1, mold_len};
        frame    = {hdr, msg_q};
        cur_byte = frame[10'd799 - {idx_q, 3'b000} -: 8];
        last_idx = 7'd63 + len_q;
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        len_d   = len_q;
        csum_d  = csum_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        drop_d  = drop_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        last_d  = last_q;
        dat_d   = dat_q;
        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (msgValid && rdy_q) begin
                    if (msgData[287:280] == 8'h41) begin
                        msg_d   = msgData;
                        len_d   = 7'd36;
                        state_d = CSUM;
                        rdy_d   = 1'b0;
                    end else if (msgData[287:280] == 8'h45 || msgData[287:280] == 8'h58) begin
                        msg_d   = msgData;
                        len_d   = 7'd19;
                        state_d = CSUM;
                        rdy_d   = 1'b0;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            CSUM: begin
                csum_d  = ~fold2;
                idx_d   = 7'd0;
                state_d = SEND;
            end
            SEND: begin
                if (vld_q && txReady && last_q) begin
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    dat_d   = 8'h00;
                    seq_d   = seq_q + 64'd1;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end else if (!vld_q || txReady) begin
                    // Output register is empty or its byte is being taken: load the next one.
                    dat_d  = cur_byte;
                    vld_d  = 1'b1;
                    last_d = (idx_q == last_idx);
                    if (idx_q != last_idx) begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= IDLE;
            msg_q   <= '0;
            len_q   <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            seq_q   <= SEQ_INIT;
            drop_q  <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            dat_q   <= dat_d;
        end
    end

    assign msgReady = rdy_q;
    assign txData   = dat_q;
    assign txValid  = vld_q;
    assign txLast   = last_q;
    assign seqNum   = seq_q;
    assign dropCnt  = drop_q;

endmodule

// File: tb/tb_itch_frame_tx.sv
// Directed bench for itch_frame_tx: frame contents, latency, stalls, drops and mid-frame reset.
module tb_itch_frame_tx;

    logic         clk;
    logic         rstN;
    logic         msgValid;
    logic         msgReady;
    logic [287:0] msgData;
    logic [7:0]   txData;
    logic         txValid;
    logic         txLast;
    logic         txReady;
    logic [63:0]  seqNum;
    logic [15:0]  dropCnt;

    itch_frame_tx dut (
        .clk      (clk),
        .rstN     (rstN),
        .msgValid (msgValid),
        .msgReady (msgReady),
        .msgData  (msgData),
        .txData   (txData),
        .txValid  (txValid),
        .txLast   (txLast),
        .txReady  (txReady),
        .seqNum   (seqNum),
        .dropCnt  (dropCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [7:0] got   [0:127];
    logic [7:0] exp_b [0:127];
    int  nb, lastpos, lat, stalls;
    bit  done, unstable, rdy_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [287:0] mk_msg(input logic [7:0] t);
        logic [287:0] m;
        m = '0;
        m[287:280] = t;
        for (int i = 1; i < 36; i++) m[287 - 8*i -: 8] = 8'(i * 7 + 3);
        return m;
    endfunction

    task automatic build_exp(input logic [287:0] m, input int len, input logic [63:0] sq,
                             input logic [15:0] cs);
        logic [511:0] h;
        h = {48'hA846D2197E2B, 48'h123456789ABC, 16'h0800,
             8'h45, 8'h00, 16'(50 + len), 16'h0000, 16'h0000, 8'h00, 8'h11, cs,
             32'h12345678, 32'hE0000000,
             16'h3E80, 16'h2710, 16'(30 + len), 16'h0000,
             80'h0, sq, 16'd1, 16'(len)};
        for (int i = 0; i < 64; i++) exp_b[i] = h[511 - 8*i -: 8];
        for (int i = 0; i < len; i++) exp_b[64 + i] = m[287 - 8*i -: 8];
    endtask

    task automatic send(input logic [287:0] m);
        int w;
        w = 0;
        @(negedge clk);
        msgValid = 1'b1;
        msgData  = m;
        while (!msgReady && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("handshake_wait", 64'(w < 100), 64'd1);
        @(posedge clk);
        #1;
        msgValid = 1'b0;
    endtask

    // Collects one frame; abort_at >= 0 pulls rstN low when that byte index is presented.
    task automatic capture(input bit rnd, input int abort_at);
        logic [7:0] hd;
        logic       hl;
        bit         held;
        nb = 0; lastpos = -1; lat = -1; stalls = 0;
        done = 0; unstable = 0; rdy_seen = 0; held = 0;
        hd = '0; hl = 1'b0;
        for (int k = 1; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (msgReady) rdy_seen = 1;
            if (held && (txValid !== 1'b1 || txData !== hd || txLast !== hl)) unstable = 1;
            if (txValid && lat < 0) lat = k - 1;
            if (abort_at >= 0 && txValid && nb == abort_at) begin
                rstN = 1'b0;
                done = 1;
            end else begin
                txReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (txValid && txReady) begin
                    got[nb] = txData;
                    if (txLast) begin
                        lastpos = nb;
                        done = 1;
                    end
                    nb++;
                    held = 0;
                end else begin
                    held = txValid;
                    if (txValid) stalls++;
                    hd = txData;
                    hl = txLast;
                end
            end
        end
        check("capture_done", 64'(done), 64'd1);
        txReady = 1'b1;
    endtask

    task automatic cmp_frame(input string tag, input int n);
        int mism;
        mism = 0;
        for (int i = 0; i < n; i++) if (got[i] !== exp_b[i]) mism++;
        check(tag, 64'(mism), 64'd0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        logic [287:0] add_m, exe_m, bad_m;
        logic [63:0]  sqv;
        bit           vseen;
        rstN = 1'b0; msgValid = 1'b0; msgData = '0; txReady = 1'b1;
        add_m = mk_msg(8'h41);
        exe_m = mk_msg(8'h45);
        bad_m = mk_msg(8'h5A);

        repeat (3) @(negedge clk);
        check("rst_msgReady", 64'(msgReady), 64'd0);
        check("rst_txValid",  64'(txValid),  64'd0);
        check("rst_txLast",   64'(txLast),   64'd0);
        check("rst_txData",   64'(txData),   64'd0);
        check("rst_seqNum",   seqNum,        64'd1);
        check("rst_dropCnt",  64'(dropCnt),  64'd0);
        rstN = 1'b1;

        // Add message, no backpressure
        build_exp(add_m, 36, 64'd1, 16'h71EB);
        send(add_m);
        capture(0, -1);
        check("add_nbytes",   64'(nb),      64'd100);
        check("add_lastpos",  64'(lastpos), 64'd99);
        check("add_latency",  64'(lat),     64'd2);
        check("add_ip_len",   {48'd0, got[16], got[17]}, 64'h0056);
        check("add_ip_csum",  {48'd0, got[24], got[25]}, 64'h71EB);
        check("add_udp_len",  {48'd0, got[38], got[39]}, 64'h0042);
        check("add_mold_len", {48'd0, got[62], got[63]}, 64'h0024);
        cmp_frame("add_frame", 100);
        check("add_rdy_low",  64'(rdy_seen), 64'd0);
        @(negedge clk);
        check("add_vld_drop", 64'(txValid), 64'd0);
        check("add_seq_after", seqNum, 64'd2);

        // Executed message
        build_exp(exe_m, 19, 64'd2, 16'h71FC);
        send(exe_m);
        capture(0, -1);
        check("exe_nbytes",   64'(nb),      64'd83);
        check("exe_lastpos",  64'(lastpos), 64'd82);
        check("exe_ip_len",   {48'd0, got[16], got[17]}, 64'h0045);
        check("exe_ip_csum",  {48'd0, got[24], got[25]}, 64'h71FC);
        check("exe_udp_len",  {48'd0, got[38], got[39]}, 64'h0031);
        check("exe_mold_len", {48'd0, got[62], got[63]}, 64'h0013);
        cmp_frame("exe_frame", 83);

        // Three Adds back to back from a fresh reset
        do_reset();
        for (int j = 0; j < 3; j++) begin
            send(add_m);
            capture(0, -1);
            sqv = {got[52], got[53], got[54], got[55], got[56], got[57], got[58], got[59]};
            check("b2b_mold_seq", sqv, 64'(j + 1));
            check("b2b_rdy_low",  64'(rdy_seen), 64'd0);
        end
        @(negedge clk);
        check("b2b_seq_after", seqNum, 64'd4);

        // Add message under pseudo-random backpressure
        build_exp(add_m, 36, 64'd4, 16'h71EB);
        send(add_m);
        capture(1, -1);
        check("stall_nbytes",  64'(nb),       64'd100);
        check("stall_stable",  64'(unstable), 64'd0);
        check("stall_latency", 64'(lat),      64'd2);
        check("stall_seen",    64'(stalls > 0), 64'd1);
        cmp_frame("stall_frame", 100);

        // Unknown message type is dropped
        do_reset();
        send(bad_m);
        @(negedge clk);
        check("drop_cnt",   64'(dropCnt),  64'd1);
        check("drop_ready", 64'(msgReady), 64'd1);
        vseen = 0;
        repeat (5) begin
            @(negedge clk);
            if (txValid) vseen = 1;
        end
        check("drop_no_tx", 64'(vseen), 64'd0);
        build_exp(add_m, 36, 64'd1, 16'h71EB);
        send(add_m);
        capture(0, -1);
        cmp_frame("post_drop_frame", 100);
        check("post_drop_nbytes", 64'(nb), 64'd100);

        // Reset in the middle of a frame
        send(add_m);
        capture(0, 40);
        @(negedge clk);
        check("abort_txValid",  64'(txValid),  64'd0);
        check("abort_txLast",   64'(txLast),   64'd0);
        check("abort_txData",   64'(txData),   64'd0);
        check("abort_msgReady", 64'(msgReady), 64'd0);
        check("abort_seqNum",   seqNum,        64'd1);
        rstN = 1'b1;
        send(add_m);
        capture(0, -1);
        check("abort_next_nbytes", 64'(nb), 64'd100);
        cmp_frame("abort_next_frame", 100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
